fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the MIPS CPU: owns the program counter, issues word requests to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC to the decode stage, whose immediate field `inst[15:0]` feeds the sign extender. It supports multi-cycle memory, downstream back-pressure through a one-entry skid buffer, and branch/jump redirect with discard of in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `imem_req` output 1: fetch request; held high with stable `imem_addr` until `imem_ack`.
- `imem_addr` output 32: word address being fetched; bits [1:0] always 00.
- `imem_ack` input 1: memory returns `imem_rdata` this cycle; ignored when `imem_req`=0.
- `imem_rdata` input 32: fetched instruction word.
- `redirect_valid` input 1: one-cycle pulse from branch/jump resolution.
- `redirect_pc` input 32: new fetch target.
- `stall` input 1: decode cannot accept; output registers hold.
- `inst_valid` output 1: `inst`/`inst_pc`/`pc_plus4` valid.
- `inst` output 32: instruction word to decode.
- `inst_pc` output 32: address of `inst`.
- `pc_plus4` output 32: `inst_pc` + 4, mod 2^32.
- `align_fault` output 1: misaligned redirect flag (see Configuration).

## Operation
- States: IDLE, FETCH, DRAIN, HOLD, FAULT.
- Reset (`rst_n`=0 at an edge): state IDLE, pc=`RESET_PC`, `imem_req`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `pc_plus4`=0, skid empty, `align_fault`=0. Reset mid-request abandons it; late ack is ignored.
- IDLE → FETCH unconditionally.
- `imem_req`=1 in FETCH and DRAIN only; `imem_addr`=pc in FETCH, latched old address in DRAIN.
- FETCH, ack, no redirect: if output free (`inst_valid`=0 or `stall`=0) load output with rdata/pc/pc+4, `inst_valid`=1; else write skid, go HOLD. pc ← pc+4 either way.
- HOLD: `imem_req`=0; when `stall`=0, skid moves to output, skid empties, → FETCH.
- Output consumed (`inst_valid`=1, `stall`=0) with no new data: `inst_valid` ← 0.
- Redirect (priority over everything, including `stall`): `inst_valid` ← 0, skid cleared, pc ← `redirect_pc`. If in FETCH without ack this cycle → DRAIN; ack in same cycle → data discarded, stay/go FETCH; HOLD/IDLE → FETCH.
- DRAIN: wait for ack, discard data, → FETCH at redirected pc. Second redirect while in DRAIN overwrites pc; remain DRAIN.
- PC arithmetic 32-bit unsigned, wraps: 32'hFFFF_FFFC + 4 = 0.

## Timing
- First `imem_req` in cycle after first edge with `rst_n`=1 (IDLE takes one cycle).
- Ack at cycle N → `inst_valid`=1 at N+1 (one-cycle latency).
- Zero-wait memory (ack same cycle as req), no stall: one instruction per cycle.
- Redirect at cycle N → `inst_valid`=0 at N+1; first redirected instruction valid no earlier than N+2.
- Outputs all registered; `imem_req`/`imem_addr` decoded from registered state only (no input-to-output combinational paths).

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]`≠00 sets `align_fault`=1 (sticky to reset), flushes output, → FAULT; FAULT drives `imem_req`=0 and ignores further redirects; in-flight request completes and is discarded before FAULT stops requesting.
- Undefined: `redirect_pc[1:0]` forced to 00, no FAULT state, `align_fault` tied 0.

## Structure
- Package `mips_fetch_pkg`: state enum type, `INST_BYTES`=4, default reset-PC constant.
- Sub-module `fetch_skid_buf`: one-entry buffer holding {inst, pc, pc_plus4} with load/unload/clear and full flag.

## Test plan
- Reset, zero-wait memory returning PC as data, no stall → `inst_pc` 0x0,0x4,0x8,0xC on consecutive cycles, first valid two cycles after reset release.
- 3-cycle ack latency → `imem_addr` stable 0x0 across wait, `inst`=rdata one cycle after ack, next req at 0x4.
- `stall` high 4 cycles during zero-wait fetch → output held, one word in skid, `imem_req`=0 in HOLD; release → no loss or duplicate, sequence contiguous.
- Redirect to 0x100 while ack pending at 0x8 → late 0x8 data discarded, next `inst_pc`=0x100.
- `RESET_PC`=0xFFFF_FFF8 → `inst_pc` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap).
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x102 → `align_fault`=1, `inst_valid`=0, `imem_req` stays 0 until reset.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and constants for the MIPS instruction fetch stage.
//   fetch_state_e  - fetch controller states
//   fetch_entry_t  - {inst, pc, pc_plus4} record passed to decode / held in the skid
//   INST_BYTES     - instruction size in bytes (PC increment)
//   DEFAULT_RESET_PC - default PC loaded on reset
package mips_fetch_pkg;

  localparam int          INST_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOLD,
    FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  // Sequential PC; 32-bit unsigned, wraps at 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a fetched word that arrived
// while decode was stalled with the output register already occupied.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture din, mark full
//   unload     : entry consumed, mark empty
//   clear      : discard entry (redirect); wins over load/unload
//   din/dout   : {inst, pc, pc_plus4}
//   full       : entry valid
module fetch_skid_buf
  import mips_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage. Owns the PC, fetches words over a
// req/ack handshake, and presents {inst, inst_pc, pc_plus4} to decode with a
// one-entry skid for back-pressure. Redirects discard in-flight fetches.
//   clk, rst_n        : clock, synchronous active-low reset
//   imem_req/addr     : fetch request, held with stable word address until ack
//   imem_ack/rdata    : memory completion and instruction word
//   redirect_valid/pc : branch/jump redirect pulse and target
//   stall             : decode cannot accept this cycle
//   inst_valid, inst, inst_pc, pc_plus4 : registered output to decode
//   align_fault       : sticky misaligned-redirect flag
// Build option FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise
// align_fault and park the unit in FAULT until reset. Without it the target's
// low two bits are forced to zero and align_fault stays 0.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic        align_fault
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  drain_addr;
  fetch_entry_t out_q;
  fetch_entry_t fetched;
  fetch_entry_t skid_q;
  logic         skid_full;
  logic         skid_load;
  logic         skid_unload;
  logic [31:0]  rpc;
  logic         misaligned;
  logic         go_fault;

`ifdef FETCH_ALIGN_CHECK_EN
  assign rpc        = redirect_pc;
  assign misaligned = |redirect_pc[1:0];
`else
  logic unused_rpc_lo;
  assign unused_rpc_lo = ^redirect_pc[1:0];
  assign rpc           = {redirect_pc[31:2], 2'b00};
  assign misaligned    = 1'b0;
`endif

  // A fault already latched stays in force across later redirects.
  assign go_fault = align_fault | misaligned;

  assign fetched = '{inst: imem_rdata, pc: pc, pc_plus4: next_pc(pc)};

  // Request decode is purely from registered state.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  assign inst     = out_q.inst;
  assign inst_pc  = out_q.pc;
  assign pc_plus4 = out_q.pc_plus4;

  // Skid only fills when a word lands while the output is occupied and stalled.
  assign skid_load   = (state == FETCH) && imem_ack && !redirect_valid
                       && inst_valid && stall;
  assign skid_unload = (state == HOLD) && !stall && !redirect_valid;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (redirect_valid),
    .din    (fetched),
    .dout   (skid_q),
    .full   (skid_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drain_addr  <= '0;
      out_q       <= '0;
      inst_valid  <= 1'b0;
      align_fault <= 1'b0;
    end else begin
      // Output consumed; reloaded below if new data arrives.
      if (inst_valid && !stall) inst_valid <= 1'b0;

      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            pc <= next_pc(pc);
            if (!inst_valid || !stall) begin
              out_q      <= fetched;
              inst_valid <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            out_q      <= skid_q;
            inst_valid <= skid_full;
            state      <= FETCH;
          end
        end
        DRAIN: begin
          // Stale word is dropped; resume (or park) once it completes.
          if (imem_ack) state <= align_fault ? FAULT : FETCH;
        end
        FAULT: ;
        default: state <= IDLE;
      endcase

      // Redirect overrides everything above, including stall.
      if (redirect_valid && state != FAULT) begin
        inst_valid <= 1'b0;
        pc         <= rpc;
        if (misaligned) align_fault <= 1'b1;
        if ((state == FETCH || state == DRAIN) && !imem_ack) begin
          // Old request still open: keep its address until memory answers.
          state <= DRAIN;
          if (state == FETCH) drain_addr <= pc;
        end else begin
          state <= go_fault ? FAULT : FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A behavioural memory with
// programmable latency answers requests; a scoreboard queues every accepted
// fetch and checks decode output order, content and handshake rules. A cycle
// table covers reset/streaming/stall, and directed sequences cover latency,
// redirect discard, reset values, PC wrap and misaligned redirects.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc, pc_plus4;
  logic        align_fault;

  // Second instance: reset PC near the top of the address space, zero-wait memory.
  logic        w_req, w_valid, w_fault;
  logic [31:0] w_addr, w_inst, w_pc, w_pc4;
  logic        w_one = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = '0;

  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  logic [31:0] dkey = '0;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .pc_plus4(pc_plus4), .align_fault(align_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_one), .imem_rdata(w_addr), .redirect_valid(w_zero),
    .redirect_pc(w_zero32), .stall(w_zero), .inst_valid(w_valid), .inst(w_inst),
    .inst_pc(w_pc), .pc_plus4(w_pc4), .align_fault(w_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  int waited = 0;
  always begin
    @(posedge clk);
    #1;
    imem_ack   = rst_n && imem_req && (waited >= lat);
    imem_rdata = imem_addr ^ dkey;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_pc = '0;
  logic [31:0] prev_addr = '0;
  bit          prev_wait = 1'b0;
  bit          discard = 1'b0;
  bit          faulted = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_pc    = 32'h0;
      discard   = 1'b0;
      faulted   = 1'b0;
      prev_wait = 1'b0;
      waited    = 0;
    end else begin
      if (prev_wait && imem_req) chk("addr_stable", imem_addr, prev_addr);
      if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'h0);
      if (faulted) chk("fault_req", 32'(imem_req), 32'(discard));
      chk("valid_vs_model", 32'(inst_valid), 32'(q.size() != 0));
      if (inst_valid && q.size() != 0) begin
        chk("sb_inst", inst, q[0].inst);
        chk("sb_inst_pc", inst_pc, q[0].pc);
        chk("sb_pc_plus4", pc_plus4, q[0].pc + 32'd4);
      end
      if (q.size() >= 2) chk("req_while_skid_full", 32'(imem_req), 32'h0);

      // Advance the model across the coming edge.
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (redirect_valid && !faulted) begin
        q.delete();
        discard = imem_req && !imem_ack;
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) faulted = 1'b1;
        else exp_pc = redirect_pc;
`else
        exp_pc = {redirect_pc[31:2], 2'b00};
`endif
      end else begin
        if (inst_valid && !stall && q.size() != 0) void'(q.pop_front());
        if (imem_req && imem_ack) begin
          if (discard) discard = 1'b0;
          else if (!faulted) begin
            chk("fetch_addr", imem_addr, exp_pc);
            q.push_back('{inst: imem_addr ^ dkey, pc: imem_addr});
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
      waited = (imem_req && !imem_ack) ? waited + 1 : 0;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vec[13];

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
    end
    if (seen) chk(name, inst_pc, exp);
    else begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for inst_valid, expected pc %h", name, exp);
    end
  endtask

  initial begin
    bit found;
    //            stall  req   addr      valid  inst_pc
    vec[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    vec[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vec[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    vec[3]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
    vec[4]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
    vec[5]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    vec[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    vec[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    vec[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    vec[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    vec[10] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10};
    vec[11] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h14};
    vec[12] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h18};

    // Zero-wait streaming with a 4-cycle stall (data = address).
    lat  = 0;
    dkey = 32'h0;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      stall = vec[k].stall;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", k), 32'(imem_req), 32'(vec[k].req));
      if (vec[k].req) chk($sformatf("tbl%0d_addr", k), imem_addr, vec[k].addr);
      chk($sformatf("tbl%0d_valid", k), 32'(inst_valid), 32'(vec[k].valid));
      if (vec[k].valid) begin
        chk($sformatf("tbl%0d_pc", k), inst_pc, vec[k].pc);
        chk($sformatf("tbl%0d_inst", k), inst, vec[k].pc);
      end
      step();
    end

    // Three-cycle memory latency.
    lat  = 3;
    dkey = 32'h1234_0000;
    do_reset();
    repeat (4) begin
      step();
      @(negedge clk);
      chk("lat_req", 32'(imem_req), 32'h1);
      chk("lat_addr_hold", imem_addr, 32'h0);
      chk("lat_no_valid", 32'(inst_valid), 32'h0);
    end
    step();
    @(negedge clk);
    chk("lat_valid", 32'(inst_valid), 32'h1);
    chk("lat_inst", inst, 32'h1234_0000);
    chk("lat_next_addr", imem_addr, 32'h4);

    // Redirect to 0x100 while the fetch at 0x8 is still pending.
    lat   = 2;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL redir_setup: timeout waiting for fetch at 0x8, got addr %h", imem_addr);
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_flush_valid", 32'(inst_valid), 32'h0);
    chk("redir_drain_addr", imem_addr, 32'h8);
    wait_valid("redir_first_pc", 32'h100);

    // Reset in mid-request: all outputs return to reset values.
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst_align_fault", 32'(align_fault), 32'h0);

    // PC wrap on the high-reset-PC instance.
    lat  = 0;
    dkey = 32'h0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    chk("wrap_inst0", w_inst, 32'hFFFF_FFF8);
    step();
    @(negedge clk);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4_1", w_pc4, 32'h0);
    step();
    @(negedge clk);
    chk("wrap_pc2", w_pc, 32'h0);
    chk("wrap_valid2", 32'(w_valid), 32'h1);

    // Redirect while stalled in HOLD beats the stall.
    stall = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("hold_redir_valid", 32'(inst_valid), 32'h0);
    step();
    stall = 1'b0;
    wait_valid("hold_redir_pc", 32'h200);

    // Redirect in the same cycle as a zero-wait ack.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    wait_valid("ack_redir_pc", 32'h300);

    // Misaligned redirect target.
    lat = 2;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_valid", 32'(inst_valid), 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", 32'(align_fault), 32'h1);
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("fault_no_req", 32'(imem_req), 32'h0);
      chk("fault_no_valid", 32'(inst_valid), 32'h0);
      chk("fault_sticky", 32'(align_fault), 32'h1);
      step();
    end
`else
    chk("mis_no_fault", 32'(align_fault), 32'h0);
    wait_valid("mis_forced_pc", 32'h100);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
